stable_matching_verify: RTL

- Sequential checker that consumes a completed matching from the combinational matcher and decides whether it is stable.
- Uses the same packed preference vector as the matcher, plus its R*logS+1 output word.
- First inverts the r->s match list and checks that it is a permutation. Then scans each s's preference list for a blocking pair, one (s,k) probe per cycle.
- Sits downstream of the matcher as its result reader/auditor.

---
 rtl/stable_matching_verify.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/stable_matching_verify.sv
// Stability auditor for a completed r->s matching: inverts the match list, checks it is a
// permutation, then probes every s preference entry for a blocking pair, one probe per cycle.
module stable_matching_verify #(
    parameter int Kr = 10,
    parameter int Ks = 10,
    parameter int S  = 10,
    parameter int R  = 10,
    localparam int logS = (S > 1) ? $clog2(S) : 1,
    localparam int logR = (R > 1) ? $clog2(R) : 1,
    localparam int PW   = R*Kr*logS + S*Ks*logR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PW-1:0]   p_input,
    input  logic [R*logS:0] match_in,
    output logic            busy,
    output logic            done,
    output logic            stable,
    output logic            valid,
    output logic            fin,
    output logic [logS-1:0] blk_s,
    output logic [logR-1:0] blk_r
);
    localparam int KW  = $clog2(Ks + 1);
    localparam int RKW = $clog2(Kr + 1);
    localparam int SB  = R*Kr*logS;

    typedef enum logic [1:0] {IDLE, INV, CHK, DONE} state_t;
    state_t state, state_nx;

    logic [R*logS:0] match_q;
    logic [logR-1:0] partner [S];
    logic [S-1:0]    seen;
    logic            dup;
    logic [logR-1:0] rc;
    logic [logS-1:0] sc;
    logic [KW-1:0]   kc;

    logic [logS-1:0] s_inv;
    logic [logR-1:0] r_probe;
    logic [logS-1:0] s_of_probe;
    logic [RKW-1:0]  rank_new;
    logic [RKW-1:0]  rank_cur;
    logic            inv_bad, last_r, last_s, last_k, is_partner, blocking;

    assign busy = (state != IDLE);

    always_comb begin
        s_inv      = match_q[logS*int'(rc) +: logS];
        inv_bad    = (int'(s_inv) >= S) || seen[s_inv];
        last_r     = (int'(rc) == R - 1);
        last_s     = (int'(sc) == S - 1);
        last_k     = (int'(kc) == Ks - 1);
        r_probe    = p_input[SB + logR*Ks*int'(sc) + logR*int'(kc) +: logR];
        s_of_probe = match_q[logS*int'(r_probe) +: logS];
        is_partner = (r_probe == partner[sc]);
        // Descending scan leaves the lowest matching index; absent entries keep rank Kr.
        rank_new   = RKW'(Kr);
        rank_cur   = RKW'(Kr);
        for (int j = Kr - 1; j >= 0; j--) begin
            if (p_input[logS*Kr*int'(r_probe) + logS*j +: logS] == sc)
                rank_new = RKW'(j);
            if (p_input[logS*Kr*int'(r_probe) + logS*j +: logS] == s_of_probe)
                rank_cur = RKW'(j);
        end
        blocking = !is_partner && (rank_new < rank_cur);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = INV;
            INV:  if (last_r) state_nx = (dup || inv_bad) ? DONE : CHK;
            CHK: begin
                if (blocking)                          state_nx = DONE;
                else if ((is_partner || last_k) && last_s) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= '0;
            seen    <= '0;
            dup     <= 1'b0;
            rc      <= '0;
            sc      <= '0;
            kc      <= '0;
            done    <= 1'b0;
            stable  <= 1'b0;
            valid   <= 1'b0;
            fin     <= 1'b0;
            blk_s   <= '0;
            blk_r   <= '0;
            for (int i = 0; i < S; i++) partner[i] <= '0;
        end else begin
            // done trails the DONE state by one edge, coinciding with the return to IDLE.
            done <= (state == DONE);
            case (state)
                IDLE: if (start) begin
                    match_q <= match_in;
                    fin     <= match_in[R*logS];
                    valid   <= 1'b0;
                    stable  <= 1'b0;
                    blk_s   <= '0;
                    blk_r   <= '0;
                    seen    <= '0;
                    dup     <= 1'b0;
                    rc      <= '0;
                end
                INV: begin
                    if (inv_bad) dup <= 1'b1;
                    else begin
                        partner[s_inv] <= rc;
                        seen[s_inv]    <= 1'b1;
                    end
                    if (last_r) begin
                        valid <= !(dup || inv_bad);
                        sc    <= '0;
                        kc    <= '0;
                    end else begin
                        rc <= rc + 1'b1;
                    end
                end
                CHK: begin
                    if (blocking) begin
                        blk_s  <= sc;
                        blk_r  <= r_probe;
                        stable <= 1'b0;
                    end else if (is_partner || last_k) begin
                        kc <= '0;
                        if (last_s) stable <= 1'b1;
                        else        sc <= sc + 1'b1;
                    end else begin
                        kc <= kc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
